shift_reg_seq_ctrl: RTL

- Command-driven sequencer for the parallel-load / left-shift buffer register.
- Accepts one command at a time over a valid/ready handshake: clear, parallel-load, or serial shift-in of a word MSB-first.
- Generates the register's LOAD, SHIFT_L, D_IN and clear strobes, and reports completion with a one-cycle done pulse carrying the resulting register contents.
- Replaces hand-timed LOAD/SHIFT_L/D_IN stimulus with a deterministic, cycle-exact controller.

---
 rtl/shift_reg_ctrl_pkg.sv | 20 ++
 rtl/shift_buff_reg.sv | 25 ++
 rtl/shift_reg_seq_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/shift_reg_ctrl_pkg.sv
// Shared encodings for the shift-register command sequencer: command opcodes
// and controller states.
package shift_reg_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_CLR    = 2'b00,
    OP_PLOAD  = 2'b01,
    OP_SERIAL = 2'b10,
    OP_RSVD   = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/shift_buff_reg.sv
// Parallel-load / left-shift buffer register. Clear has priority over load,
// and load has priority over shift; with no strobe active the contents hold.
module shift_buff_reg #(
  parameter int REG_SIZE = 4
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                load,
  input  logic                shift_l,
  input  logic                d_in,
  input  logic [REG_SIZE-1:0] d,
  output logic [REG_SIZE-1:0] q
);

  always_ff @(posedge clk) begin
    if (clear) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_l) begin
      q <= {q[REG_SIZE-2:0], d_in};
    end
  end

endmodule

// File: rtl/shift_reg_seq_ctrl.sv
// Command-driven sequencer that generates clear/LOAD/SHIFT_L/D_IN strobes for
// shift_buff_reg and reports completion with a one-cycle done pulse.
module shift_reg_seq_ctrl
  import shift_reg_ctrl_pkg::*;
#(
  parameter int REG_SIZE = 4,
  parameter int CNT_W    = $clog2(REG_SIZE + 1)
) (
  input  logic                CLOCK,
  input  logic                CLEAR,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [REG_SIZE-1:0] cmd_data,
  output logic                busy,
  output logic                done_valid,
  output logic                done_err,
  output logic [REG_SIZE-1:0] Q,
  output state_t              state_dbg
);

  // Handshake: a command transfers on the rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is only offered in IDLE outside CLEAR,
  // and a producer seeing cmd_ready low must hold cmd_valid and its payload.

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REG_SIZE - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REG_SIZE-1:0] latch_q, latch_d;
  logic                err_q, err_d;
  logic                load_q, load_d;
  logic                shift_q, shift_d;
  logic                clr_q, clr_d;
  logic                din_q, din_d;
  logic                accept;

  assign cmd_ready  = (state_q == S_IDLE) && !CLEAR;
  assign accept     = cmd_valid && cmd_ready;
  assign busy       = (state_q != S_IDLE);
  assign done_valid = (state_q == S_DONE);
  assign done_err   = done_valid && err_q;
  assign state_dbg  = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch_d = latch_q;
    err_d   = err_q;
    load_d  = 1'b0;
    shift_d = 1'b0;
    clr_d   = 1'b0;
    din_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          latch_d = cmd_data;
          cnt_d   = '0;
          err_d   = 1'b0;
          case (op_t'(cmd_op))
            OP_CLR: begin
              state_d = S_CLR;
              clr_d   = 1'b1;
            end
            OP_PLOAD: begin
              state_d = S_LOAD;
              load_d  = 1'b1;
            end
            OP_SERIAL: begin
              state_d = S_SHIFT;
              shift_d = 1'b1;
            end
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_CLR, S_LOAD: state_d = S_DONE;
      S_SHIFT: begin
        if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          shift_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // D_IN for the upcoming shift cycle: word sent MSB first as cnt rises.
    for (int i = 0; i < REG_SIZE; i++) begin
      if (shift_d && (cnt_d == CNT_W'(REG_SIZE - 1 - i))) begin
        din_d = latch_d[i];
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      latch_q <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
      shift_q <= 1'b0;
      clr_q   <= 1'b0;
      din_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      err_q   <= err_d;
      load_q  <= load_d;
      shift_q <= shift_d;
      clr_q   <= clr_d;
      din_q   <= din_d;
    end
  end

  shift_buff_reg #(
    .REG_SIZE(REG_SIZE)
  ) u_reg (
    .clk    (CLOCK),
    .clear  (CLEAR | clr_q),
    .load   (load_q),
    .shift_l(shift_q),
    .d_in   (din_q),
    .d      (latch_q),
    .q      (Q)
  );

endmodule
